fir_coef_loader: RTL

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_pkg.sv | 18 +
 rtl/coef_ram.sv | 38 +++
 rtl/fir_coef_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient path.
// Used by the coefficient loader and the downstream filter.
package fir_pkg;

  localparam int unsigned FIR_COEF_W  = 25;
  localparam int unsigned FIR_MAX_LEN = 64;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } fir_state_e;

  // A start is only honoured for 1 <= len <= max_len.
  function automatic logic len_ok(input logic [31:0] len, input int unsigned max_len);
    return (len != 32'd0) && (len <= 32'(max_len));
  endfunction

endpackage

// File: rtl/coef_ram.sv
// Coefficient storage: single write port, registered read port.
// Contents survive reset; only the read register is cleared.
module coef_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 25,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value when not enabled so the filter input stays stable in idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fir_coef_loader.sv
// Buffers CPU-written FIR coefficients and shifts them into the filter chain,
// highest index first, on a validated start request.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned MAX_LEN = FIR_MAX_LEN,
  parameter int unsigned COEF_W  = FIR_COEF_W,
  localparam int unsigned AW     = $clog2(MAX_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [COEF_W-1:0] i_wr_data,
  input  logic              i_start,
  input  logic [31:0]       i_len,
  output logic [COEF_W-1:0] o_cfg_din,
  output logic              o_cfg_ce,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_wr_drop
);

  fir_state_e r_state, w_state_nxt;
  logic [AW-1:0] r_count, w_count_nxt;
  logic          r_cfg_ce, w_cfg_ce_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_wr_drop, w_wr_drop_nxt;
  logic          w_we;
  logic          w_re;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_cfg_ce  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_cfg_ce  <= w_cfg_ce_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_cfg_ce_nxt  = 1'b0;
    w_err_nxt     = r_err;
    w_wr_drop_nxt = r_wr_drop;
    w_we          = 1'b0;
    w_re          = 1'b0;
    // Back in idle with the last shift still on the outputs means that shift just ended.
    w_done_nxt    = r_cfg_ce && (r_state == StIdle);

    unique case (r_state)
      StIdle: begin
        w_we = i_wr_en;
        if (i_start) begin
          if (len_ok(i_len, MAX_LEN)) begin
            w_err_nxt     = 1'b0;
            w_wr_drop_nxt = 1'b0;
            w_count_nxt   = AW'(i_len - 32'd1);
            w_state_nxt   = StShift;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      StShift: begin
        // The RAM read register lands mem[count] on the same edge that raises cfg_ce.
        w_re         = 1'b1;
        w_cfg_ce_nxt = 1'b1;
        if (i_wr_en) begin
          w_wr_drop_nxt = 1'b1;
        end
        if (r_count == '0) begin
          w_state_nxt = StIdle;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  coef_ram #(
    .DEPTH (MAX_LEN),
    .WIDTH (COEF_W)
  ) u_coef_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_re    (w_re),
    .i_raddr (r_count),
    .o_rdata (o_cfg_din)
  );

  assign o_cfg_ce  = r_cfg_ce;
  assign o_busy    = r_cfg_ce;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_wr_drop = r_wr_drop;

endmodule
